// File: rtl/riscv_defines.sv
// riscv_defines
//   Shared definitions for the RV32M multiply/divide sequencer.
//   - md_op_e    : funct3 encodings of the M-extension instructions
//   - md_state_e : sequencer FSM states
//   - WORD_WIDTH : operand/result width
//   - MD_CYCLES  : iteration count (equals WORD_WIDTH)
//   - md_special_result : result for divide-by-zero / signed overflow
package riscv_defines;

   localparam int WORD_WIDTH = 32;
   localparam int MD_CYCLES  = 32;

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2,
      MD_DONE = 2'd3
   } md_state_e;

   // RISC-V defines results for the two exceptional divide cases instead of
   // trapping. div_ovf and divide-by-zero are mutually exclusive (overflow
   // needs b == all ones), so a single flag is enough to pick between them.
   function automatic logic [WORD_WIDTH-1:0] md_special_result(
      input md_op_e                op,
      input logic                  div_ovf,
      input logic [WORD_WIDTH-1:0] dividend
   );
      logic [WORD_WIDTH-1:0] res;
      if (div_ovf) begin
         res = (op == MD_DIV) ? {1'b1, {(WORD_WIDTH-1){1'b0}}} : '0;
      end else if ((op == MD_DIV) || (op == MD_DIVU)) begin
         res = '1;
      end else begin
         res = dividend;
      end
      return res;
   endfunction

endpackage

// File: rtl/md_iter_step.sv
// md_iter_step
//   One combinational iteration of the multiply/divide loop.
//   Multiply (is_div_i=0): shift-add, LSB first. If acc[0] is set the
//     multiplicand is added into the upper half, then the whole 64-bit
//     accumulator shifts right by one (the carry enters at the top).
//   Divide (is_div_i=1): restoring shift-subtract, MSB first. The
//     accumulator shifts left by one; the divisor is trial-subtracted from
//     the upper half and restored on borrow. The quotient bit (~borrow) is
//     left for the caller to insert at bit 0, which is returned as 0.
// Ports
//   acc_i     in  2*WIDTH : accumulator ({remainder, quotient} for divide)
//   operand_i in  WIDTH   : multiplicand or divisor magnitude
//   is_div_i  in  1       : 1 = divide step, 0 = multiply step
//   acc_o     out 2*WIDTH : next accumulator
//   borrow_o  out 1       : trial subtraction borrowed (divide only)
module md_iter_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]   operand_i,
   input  logic               is_div_i,
   output logic [2*WIDTH-1:0] acc_o,
   output logic               borrow_o
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH-1:0] diff;

   always_comb begin
      sum       = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
      // The shifted partial remainder can need WIDTH+1 bits when the divisor
      // has its MSB set, so the compare is done one bit wider.
      rem_shift = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
      // When no borrow occurs the true difference is below the divisor and
      // therefore fits in WIDTH bits, so modular subtraction is exact.
      diff      = rem_shift[WIDTH-1:0] - operand_i;

      acc_o    = {sum, acc_i[WIDTH-1:1]};
      borrow_o = 1'b0;
      if (is_div_i) begin
         borrow_o                  = (rem_shift < {1'b0, operand_i});
         acc_o[2*WIDTH-1:WIDTH]    = borrow_o ? rem_shift[WIDTH-1:0] : diff;
         acc_o[WIDTH-1:0]          = {acc_i[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer
//   Multi-cycle RV32M multiply/divide unit for the execute stage. Operands
//   are reduced to magnitudes, iterated for MD_CYCLES cycles through
//   md_iter_step, sign-corrected in FIX and presented for one cycle in DONE.
//   Timeline: cycle 0 IDLE (start), 1..32 CALC, 33 FIX, 34 DONE.
//   Optional macro MD_EARLY_EXIT_EN: divide-by-zero and signed overflow
//   skip the loop and go IDLE -> DONE with the special-case result.
// Ports
//   clk_i       in  1          : core clock
//   rst_i       in  1          : synchronous active-high reset
//   md_en_i     in  1          : MD instruction present in EX
//   md_op_i     in  3          : funct3 (md_op_e)
//   operand_a_i in  WORD_WIDTH : rs1
//   operand_b_i in  WORD_WIDTH : rs2
//   kill_i      in  1          : flush, abort current operation
//   stall_o     out 1          : hold IF/ID/EX
//   valid_o     out 1          : result_o valid this cycle
//   result_o    out WORD_WIDTH : rd write data
module md_sequencer
   import riscv_defines::*;
#(
   parameter int WORD_WIDTH = 32,
   parameter int MD_CYCLES  = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  md_en_i,
   input  logic [2:0]            md_op_i,
   input  logic [WORD_WIDTH-1:0] operand_a_i,
   input  logic [WORD_WIDTH-1:0] operand_b_i,
   input  logic                  kill_i,
   output logic                  stall_o,
   output logic                  valid_o,
   output logic [WORD_WIDTH-1:0] result_o
);

   localparam int AW = 2 * WORD_WIDTH;
   localparam int CW = $clog2(MD_CYCLES) + 1;
   localparam logic [WORD_WIDTH-1:0] INT_MIN = {1'b1, {(WORD_WIDTH-1){1'b0}}};

   md_state_e             state_reg, state_next;
   md_op_e                op_reg;
   logic                  sign_reg;
   logic                  div_zero_reg;
   logic                  div_ovf_reg;
   logic [WORD_WIDTH-1:0] operand_reg;   // multiplicand or divisor magnitude
   logic [WORD_WIDTH-1:0] load_reg;      // multiplier or dividend magnitude
   logic [WORD_WIDTH-1:0] dividend_reg;  // raw rs1, needed for REM by zero
   logic [AW-1:0]         acc_reg;
   logic [CW-1:0]         cnt_reg;
   logic [WORD_WIDTH-1:0] result_reg;

   // ---------------- operand decode (IDLE capture) ----------------
   md_op_e                op_in;
   logic                  signed_a_in, signed_b_in;
   logic                  neg_a_in, neg_b_in;
   logic                  sign_in;
   logic                  div_zero_in, div_ovf_in;
   logic [WORD_WIDTH-1:0] mag_a_in, mag_b_in;
   logic                  start;

   assign op_in = md_op_e'(md_op_i);
   assign start = (state_reg == MD_IDLE) && md_en_i && !kill_i;

   always_comb begin
      signed_a_in = 1'b0;
      signed_b_in = 1'b0;
      case (op_in)
         MD_MULH, MD_DIV, MD_REM: begin
            signed_a_in = 1'b1;
            signed_b_in = 1'b1;
         end
         MD_MULHSU: signed_a_in = 1'b1;
         default: ;
      endcase

      neg_a_in = signed_a_in && operand_a_i[WORD_WIDTH-1];
      neg_b_in = signed_b_in && operand_b_i[WORD_WIDTH-1];
      mag_a_in = neg_a_in ? -operand_a_i : operand_a_i;
      mag_b_in = neg_b_in ? -operand_b_i : operand_b_i;

      // REM takes the dividend's sign; MULHSU's b is unsigned so neg_b is 0.
      case (op_in)
         MD_MULH, MD_DIV:   sign_in = neg_a_in ^ neg_b_in;
         MD_MULHSU, MD_REM: sign_in = neg_a_in;
         default:           sign_in = 1'b0;
      endcase

      div_zero_in = md_op_i[2] && (operand_b_i == '0);
      div_ovf_in  = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
                    (operand_a_i == INT_MIN) && (operand_b_i == '1);
   end

   // ---------------- iteration datapath ----------------
   logic [AW-1:0] step_acc_in, step_acc;
   logic          step_borrow;

   // The accumulator is cleared on start; the multiplier/dividend enters on
   // the first iteration so the start cycle only has to capture operands.
   assign step_acc_in = (cnt_reg == '0) ? {{WORD_WIDTH{1'b0}}, load_reg} : acc_reg;

   md_iter_step #(
      .WIDTH(WORD_WIDTH)
   ) u_iter_step (
      .acc_i    (step_acc_in),
      .operand_i(operand_reg),
      .is_div_i (op_reg[2]),
      .acc_o    (step_acc),
      .borrow_o (step_borrow)
   );

   // ---------------- sign fix and result select ----------------
   logic [AW-1:0]         prod_fixed;
   logic [WORD_WIDTH-1:0] quo_fixed, rem_fixed;
   logic [WORD_WIDTH-1:0] fix_result;

   always_comb begin
      prod_fixed = sign_reg ? -acc_reg : acc_reg;
      quo_fixed  = sign_reg ? -acc_reg[WORD_WIDTH-1:0] : acc_reg[WORD_WIDTH-1:0];
      rem_fixed  = sign_reg ? -acc_reg[AW-1:WORD_WIDTH] : acc_reg[AW-1:WORD_WIDTH];
      case (op_reg)
         MD_MUL:                         fix_result = prod_fixed[WORD_WIDTH-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU:   fix_result = prod_fixed[AW-1:WORD_WIDTH];
         MD_DIV, MD_DIVU:                fix_result = quo_fixed;
         default:                        fix_result = rem_fixed;
      endcase
      if (div_zero_reg || div_ovf_reg) begin
         fix_result = md_special_result(op_reg, div_ovf_reg, dividend_reg);
      end
   end

   // ---------------- FSM ----------------
   always_comb begin
      state_next = state_reg;
      if (kill_i) begin
         state_next = MD_IDLE;
      end else begin
         case (state_reg)
            MD_IDLE: begin
               if (md_en_i) begin
`ifdef MD_EARLY_EXIT_EN
                  state_next = (div_zero_in || div_ovf_in) ? MD_DONE : MD_CALC;
`else
                  state_next = MD_CALC;
`endif
               end
            end
            MD_CALC: begin
               if (cnt_reg == CW'(MD_CYCLES - 1)) begin
                  state_next = MD_FIX;
               end
            end
            MD_FIX:  state_next = MD_DONE;
            default: state_next = MD_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg    <= MD_IDLE;
         op_reg       <= MD_MUL;
         sign_reg     <= 1'b0;
         div_zero_reg <= 1'b0;
         div_ovf_reg  <= 1'b0;
         operand_reg  <= '0;
         load_reg     <= '0;
         dividend_reg <= '0;
         acc_reg      <= '0;
         cnt_reg      <= '0;
         result_reg   <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            MD_IDLE: begin
               if (start) begin
                  op_reg       <= op_in;
                  sign_reg     <= sign_in;
                  div_zero_reg <= div_zero_in;
                  div_ovf_reg  <= div_ovf_in;
                  dividend_reg <= operand_a_i;
                  acc_reg      <= '0;
                  cnt_reg      <= '0;
                  if (md_op_i[2]) begin
                     operand_reg <= mag_b_in;   // divisor
                     load_reg    <= mag_a_in;   // dividend
                  end else begin
                     operand_reg <= mag_a_in;   // multiplicand
                     load_reg    <= mag_b_in;   // multiplier
                  end
`ifdef MD_EARLY_EXIT_EN
                  if (div_zero_in || div_ovf_in) begin
                     result_reg <= md_special_result(op_in, div_ovf_in, operand_a_i);
                  end
`endif
               end
            end
            MD_CALC: begin
               acc_reg <= {step_acc[AW-1:1], op_reg[2] ? ~step_borrow : step_acc[0]};
               cnt_reg <= cnt_reg + CW'(1);
            end
            MD_FIX: result_reg <= fix_result;
            default: ;
         endcase
      end
   end

   assign stall_o  = md_en_i && (state_reg != MD_DONE) && !kill_i && !rst_i;
   assign valid_o  = (state_reg == MD_DONE);
   assign result_o = result_reg;

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer
//   Directed self-checking bench for md_sequencer. Each task drives one
//   scenario and compares outputs against hand-computed values.
//   Honours MD_EARLY_EXIT_EN for the expected latency of special cases.
module tb_md_sequencer;

`ifdef MD_EARLY_EXIT_EN
   localparam int SPECIAL_CYC = 1;
`else
   localparam int SPECIAL_CYC = 34;
`endif
   localparam int NORMAL_CYC = 34;

   logic        clk;
   logic        rst;
   logic        md_en;
   logic [2:0]  md_op;
   logic [31:0] opa;
   logic [31:0] opb;
   logic        kill;
   logic        stall;
   logic        valid;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   md_sequencer #(
      .WORD_WIDTH(32),
      .MD_CYCLES (32)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .md_en_i    (md_en),
      .md_op_i    (md_op),
      .operand_a_i(opa),
      .operand_b_i(opb),
      .kill_i     (kill),
      .stall_o    (stall),
      .valid_o    (valid),
      .result_o   (result)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Runs one operation from cycle 0 until valid_o; checks latency, result
   // and that stall_o was high on every cycle before DONE and low in DONE.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_cyc, input string name);
      int  cyc;
      int  bad_stall;
      bit  seen;
      @(negedge clk);
      md_en = 1'b1;
      md_op = op;
      opa   = a;
      opb   = b;
      cyc       = 0;
      bad_stall = -1;
      seen      = 1'b0;
      while (cyc < 80) begin
         #1;
         if (valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (stall !== 1'b1 && bad_stall < 0) bad_stall = cyc;
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s timeout: no valid_o within 80 cycles, required at cycle %0d", name, exp_cyc);
         md_en = 1'b0;
         return;
      end
      if (stall !== 1'b0 && bad_stall < 0) bad_stall = cyc;
      md_en = 1'b0;
      $display("op %-8s a=%h b=%h result=%h valid_cycle=%0d", name, a, b, result, cyc);
      if (cyc != exp_cyc) begin
         errors++;
         $display("FAIL %s latency: valid at cycle %0d, required %0d", name, cyc, exp_cyc);
      end
      checks++;
      if (result !== exp_res) begin
         errors++;
         $display("FAIL %s result: got %h, required %h", name, result, exp_res);
      end
      checks++;
      if (bad_stall >= 0) begin
         errors++;
         $display("FAIL %s stall: wrong stall_o at cycle %0d (high required for cycles 0..%0d)",
                  name, bad_stall, exp_cyc - 1);
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      md_en = 1'b1;
      md_op = 3'd0;
      opa   = 32'd3;
      opb   = 32'd4;
      kill  = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL reset stall: got %b, required 0", stall);
      end
      checks++;
      if (valid !== 1'b0) begin
         errors++;
         $display("FAIL reset valid: got %b, required 0", valid);
      end
      checks++;
      if (result !== 32'h0) begin
         errors++;
         $display("FAIL reset result: got %h, required 00000000", result);
      end
      checks++;
      if (dut.state_reg !== riscv_defines::MD_IDLE) begin
         errors++;
         $display("FAIL reset state: got %0d, required IDLE", dut.state_reg);
      end
      md_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      $display("reset released");
   endtask

   task automatic test_mul();
      run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, NORMAL_CYC, "MUL");
      run_op(3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, NORMAL_CYC, "MUL_wrap");
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, NORMAL_CYC, "MULH");
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, NORMAL_CYC, "MULH_m1");
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, NORMAL_CYC, "MULHU");
      run_op(3'd3, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, NORMAL_CYC, "MULHU_2");
      run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, NORMAL_CYC, "MULHSU");
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NORMAL_CYC, "MULHSU_u");
   endtask

   task automatic test_div();
      run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, NORMAL_CYC, "DIV");
      run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, NORMAL_CYC, "REM");
      run_op(3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, NORMAL_CYC, "DIV_negb");
      run_op(3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, NORMAL_CYC, "REM_negb");
      run_op(3'd7, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, NORMAL_CYC, "REMU");
      run_op(3'd5, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, NORMAL_CYC, "DIVU_big");
      run_op(3'd7, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, NORMAL_CYC, "REMU_big");
   endtask

   task automatic test_special();
      run_op(3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, SPECIAL_CYC, "DIVU_z");
      run_op(3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, SPECIAL_CYC, "DIV_z");
      run_op(3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, SPECIAL_CYC, "REM_z");
      run_op(3'd7, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, SPECIAL_CYC, "REMU_z");
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_CYC, "DIV_ovf");
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPECIAL_CYC, "REM_ovf");
   endtask

   task automatic test_kill();
      bit saw_valid;
      @(negedge clk);
      md_en = 1'b1;
      md_op = 3'd0;
      opa   = 32'd9;
      opb   = 32'd9;
      repeat (10) @(negedge clk);   // now in cycle 10
      kill = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL kill stall: got %b in kill cycle, required 0", stall);
      end
      @(negedge clk);               // cycle 11
      kill  = 1'b0;
      md_en = 1'b0;
      #1;
      checks++;
      if (dut.state_reg !== riscv_defines::MD_IDLE) begin
         errors++;
         $display("FAIL kill state: got %0d at cycle 11, required IDLE", dut.state_reg);
      end
      saw_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (valid !== 1'b0) saw_valid = 1'b1;
         @(negedge clk);
         #1;
      end
      checks++;
      if (saw_valid) begin
         errors++;
         $display("FAIL kill valid: got valid_o=1 after kill, required 0");
      end
      $display("op KILL    a=%h b=%h aborted at cycle 10", 32'd9, 32'd9);
   endtask

   task automatic test_reset_abort();
      run_op(3'd0, 32'd6, 32'd7, 32'd42, NORMAL_CYC, "MUL_pre");
      @(negedge clk);
      md_en = 1'b1;
      md_op = 3'd1;
      opa   = 32'h8000_0000;
      opb   = 32'h8000_0000;
      repeat (20) @(negedge clk);   // now in cycle 20
      rst = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL rst stall: got %b while rst_i high, required 0", stall);
      end
      @(negedge clk);               // cycle 21
      #1;
      checks++;
      if (dut.state_reg !== riscv_defines::MD_IDLE) begin
         errors++;
         $display("FAIL rst state: got %0d at cycle 21, required IDLE", dut.state_reg);
      end
      checks++;
      if (valid !== 1'b0 || result !== 32'h0) begin
         errors++;
         $display("FAIL rst outputs: valid=%b result=%h, required 0 and 00000000", valid, result);
      end
      md_en = 1'b0;
      rst   = 1'b0;
      $display("op RESET   aborted at cycle 20");
      run_op(3'd3, 32'h0000_0003, 32'h8000_0000, 32'h0000_0001, NORMAL_CYC, "MULHU_post");
   endtask

   task automatic test_back_to_back();
      int cyc;
      int first_cyc;
      int second_cyc;
      first_cyc  = -1;
      second_cyc = -1;
      @(negedge clk);
      md_en = 1'b1;
      md_op = 3'd0;
      opa   = 32'd3;
      opb   = 32'd5;
      cyc   = 0;
      while (cyc < 120 && second_cyc < 0) begin
         #1;
         if (valid === 1'b1) begin
            if (first_cyc < 0) begin
               first_cyc = cyc;
               $display("op B2B_1   a=%h b=%h result=%h valid_cycle=%0d", 32'd3, 32'd5, result, cyc);
               checks++;
               if (result !== 32'd15) begin
                  errors++;
                  $display("FAIL b2b first result: got %h, required 0000000f", result);
               end
               // next MD instruction enters EX right after DONE
               opa = 32'h0000_FFFF;
               opb = 32'h0001_0001;
            end else begin
               second_cyc = cyc;
               $display("op B2B_2   a=%h b=%h result=%h valid_cycle=%0d", opa, opb, result, cyc);
               md_en = 1'b0;
            end
         end
         @(negedge clk);
         cyc++;
      end
      md_en = 1'b0;
      checks++;
      if (first_cyc != NORMAL_CYC) begin
         errors++;
         $display("FAIL b2b first latency: valid at cycle %0d, required %0d", first_cyc, NORMAL_CYC);
      end
      checks++;
      if (second_cyc < 0 || (second_cyc - first_cyc) != 35) begin
         errors++;
         $display("FAIL b2b spacing: second valid %0d cycles after first, required 35",
                  second_cyc - first_cyc);
      end
      checks++;
      if (second_cyc >= 0 && result !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL b2b second result: got %h, required ffffffff", result);
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_kill();
      test_reset_abort();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
